// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin arbiter that shares the single write port of a small output
//   register bank (a, b, c: DW bits; d: 1 bit) among NREQ requesters.
//   One write commits per clock.
//   A requester may lock the port for a burst of up to LOCK_MAX grants.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   req      per-requester write request
//   lock     per-requester request to hold the port after this grant
//   wr_addr  flattened 2-bit target selects (0=a 1=b 2=c 3=d), slice i = [2i+1:2i]
//   wr_data  flattened write data, slice i = [DW*i+DW-1:DW*i]
//   gnt      one-hot combinational grant
//   owner    index of the locking requester (valid while locked)
//   locked   arbiter is holding the port for owner
//   a, b, c  registered bank outputs
//   d        registered flag output
module reg_write_arbiter #(
   parameter int unsigned NREQ     = 3,
   parameter int unsigned DW       = 8,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      lock,
   input  logic [2*NREQ-1:0]    wr_addr,
   input  logic [DW*NREQ-1:0]   wr_data,
   output logic [NREQ-1:0]      gnt,
   output logic [2:0]           owner,
   output logic                 locked,
   output logic [DW-1:0]        a,
   output logic [DW-1:0]        b,
   output logic [DW-1:0]        c,
   output logic                 d
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [8:0] LOCK_LIM = 9'(LOCK_MAX);

   state_t      state, state_nxt;
   logic [2:0]  rr_ptr, rr_nxt;
   logic [2:0]  owner_nxt;
   logic [7:0]  beat_cnt, beat_nxt;
   logic [8:0]  beat_inc;
   logic        any_gnt;
   logic [2:0]  gnt_idx;
   logic [1:0]  sel_addr;
   logic [DW-1:0] sel_data;

   assign locked   = (state == LOCKED);
   assign beat_inc = {1'b0, beat_cnt} + 9'd1;

   always_comb begin
      int unsigned idx;
      gnt       = '0;
      any_gnt   = 1'b0;
      gnt_idx   = '0;
      state_nxt = state;
      rr_nxt    = rr_ptr;
      owner_nxt = owner;
      beat_nxt  = beat_cnt;
      idx       = 0;
      if (state == IDLE) begin
         // Scan rr_ptr+1, rr_ptr+2, ... wrapping at NREQ; the first request wins.
         for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_gnt && req[idx]) begin
               any_gnt = 1'b1;
               gnt_idx = idx[2:0];
            end
         end
         if (any_gnt) begin
            gnt[gnt_idx] = 1'b1;
            rr_nxt       = gnt_idx;
            // With LOCK_MAX=1 the entry grant is already the last beat.
            if (lock[gnt_idx] && (LOCK_MAX > 1)) begin
               state_nxt = LOCKED;
               owner_nxt = gnt_idx;
               beat_nxt  = 8'd1;
            end
         end
      end else begin
         if (req[owner]) begin
            any_gnt      = 1'b1;
            gnt_idx      = owner;
            gnt[owner]   = 1'b1;
            beat_nxt     = beat_inc[7:0];
            // beat_cnt counts completed beats, so this grant is beat beat_cnt+1.
            if (!lock[owner] || (beat_inc >= LOCK_LIM)) begin
               state_nxt = IDLE;
               beat_nxt  = '0;
            end
         end
      end
   end

   assign sel_addr = wr_addr[2*int'(gnt_idx) +: 2];
   assign sel_data = wr_data[DW*int'(gnt_idx) +: DW];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= 3'(NREQ - 1);
         owner    <= '0;
         beat_cnt <= '0;
         a        <= '0;
         b        <= '0;
         c        <= '0;
         d        <= 1'b1;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         owner    <= owner_nxt;
         beat_cnt <= beat_nxt;
         if (any_gnt) begin
            case (sel_addr)
               2'd0:    a <= sel_data;
               2'd1:    b <= sel_data;
               2'd2:    c <= sel_data;
               default: d <= sel_data[0];
            endcase
         end
      end
   end

endmodule
